// File: rtl/sched_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
// Holds the FSM state encoding, requester count/ID width, and the rotate-then-priority-encode pick.
// Pure declarations; no timing or flow-control behaviour of its own.
package sched_pkg;

  localparam int NREQ = 16;
  localparam int IDW  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic           found;
    logic [IDW-1:0] idx;
  } pick_t;

  // Rotate req so that bit ptr lands at position 0, take the lowest set bit,
  // then add ptr back to get the absolute requester index (wraps mod NREQ).
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [IDW-1:0] ptr);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    pick_t             res;
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        res.found = 1'b1;
        res.idx   = ptr + i[IDW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder.sv
// 4-to-16 one-hot decoder with enable; all-zero output when disabled.
// Latency: purely combinational.
// No flow control; output follows inputs.
module decoder (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] y
);

  // Set exactly one bit when enabled, otherwise drive zero.
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/grant_scheduler.sv
// Round-robin owner selection for one shared resource among 16 level-sensitive requesters.
// Latency: grant visible the cycle after req is sampled in IDLE; one idle cycle between owners.
// Owner holds until it drops req or MAX_HOLD cycles elapse; other requests wait until IDLE.
module grant_scheduler
  import sched_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid,
  output logic            timeout
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t         state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  hold;
  pick_t          pick;
  logic           busy;

  // Next candidate owner, scanning from ptr upward with wrap.
  always_comb begin
    pick = rr_pick(req, ptr);
  end

  // Grant FSM: pick in IDLE, hold in BUSY until release or hold limit, then rotate.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      hold    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && pick.found) begin
            owner <= pick.idx;
            hold  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!req[owner]) begin
            state <= IDLE;
            ptr   <= owner + 1'b1;
          end else if (hold == HOLD_LAST) begin
            state   <= IDLE;
            ptr     <= owner + 1'b1;
            timeout <= 1'b1;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs come from registers only, so req cannot glitch the grant.
  always_comb begin
    busy        = (state == BUSY);
    grant_valid = busy;
    grant_id    = owner;
  end

  decoder u_dec (
    .sel (owner),
    .en  (busy),
    .y   (grant)
  );

endmodule
